// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receive path feeding the byte FIFO.
package uart_pkg;
  localparam int DATA_W  = 8;
  localparam int OVS_DEF = 16;
  localparam int DIV_DEF = 27;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_e;
endpackage

// File: rtl/uart_rx_fifo_feeder_if.sv
// Write-side handshake between the UART receiver and the dual-clock byte FIFO.
interface uart_rx_fifo_feeder_if;
  import uart_pkg::*;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              fifo_full;

  modport master (output wr_en, output wr_data, input fifo_full);
  modport slave  (input wr_en, input wr_data, output fifo_full);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clk_w cycles, re-phased by restart.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk_w,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) cnt_d = '0;
  end

  always_ff @(posedge clk_w or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// 8N1 UART receiver that pushes each good byte into the FIFO write port,
// with sticky overrun / framing flags and a count of accepted bytes.
module uart_rx_fifo_feeder
  import uart_pkg::*;
#(
  parameter int DIV   = DIV_DEF,
  parameter int OVS   = OVS_DEF,
  parameter int CNT_W = 16
) (
  input  logic                  clk_w,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  err_clr,
  uart_rx_fifo_feeder_if.master fifo,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy,
  output logic [CNT_W-1:0]      rx_count
);
  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVS - 1);

  state_e            state_q;
  logic              rx_meta_q, rx_s_q;
  logic [TW-1:0]     tcnt_q;
  logic [2:0]        bitcnt_q;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              wr_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              frame_err_q, overrun_q;
  logic [CNT_W-1:0]  rx_count_q;
  logic              tick, restart;

  // Synchroniser presets high so reset looks like an idle line.
  always_ff @(posedge clk_w or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Re-phase the tick counter on the start-bit edge so samples land mid-bit.
  assign restart = (state_q == ST_IDLE) && !rx_s_q;
  assign shreg_d = {rx_s_q, shreg_q[DATA_W-1:1]};

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_w   (clk_w),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk_w or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tcnt_q      <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_count_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      // Clear first so a set later in this block takes priority.
      if (err_clr) begin
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            state_q <= ST_START;
            tcnt_q  <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tcnt_q == HALF_LAST) begin
              tcnt_q   <= '0;
              bitcnt_q <= '0;
              state_q  <= rx_s_q ? ST_IDLE : ST_DATA;
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tcnt_q == BIT_LAST) begin
              tcnt_q   <= '0;
              shreg_q  <= shreg_d;
              bitcnt_q <= bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) state_q <= ST_STOP;
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tcnt_q == BIT_LAST) begin
              tcnt_q <= '0;
              if (rx_s_q) begin
                state_q <= ST_IDLE;
                if (!fifo.fifo_full) begin
                  wr_en_q    <= 1'b1;
                  wr_data_q  <= shreg_q;
                  rx_count_q <= rx_count_q + CNT_W'(1);
                end else begin
                  overrun_q <= 1'b1;
                end
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= ST_WAIT_IDLE;
              end
            end else begin
              tcnt_q <= tcnt_q + TW'(1);
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo.wr_en   = wr_en_q;
  assign fifo.wr_data = wr_data_q;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != ST_IDLE);
  assign rx_count     = rx_count_q;
endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// Directed bench for uart_rx_fifo_feeder: table of single frames plus hand-written corner sequences.
module tb_uart_rx_fifo_feeder;
  localparam int DIV   = 2;
  localparam int OVS   = 16;
  localparam int CNT_W = 16;
  localparam int BIT   = DIV * OVS;

  logic             clk_w = 1'b0;
  logic             rst;
  logic             rx;
  logic             err_clr;
  logic             frame_err, overrun, busy;
  logic [CNT_W-1:0] rx_count;

  uart_rx_fifo_feeder_if fif();

  uart_rx_fifo_feeder #(.DIV(DIV), .OVS(OVS), .CNT_W(CNT_W)) dut (
    .clk_w     (clk_w),
    .rst       (rst),
    .rx        (rx),
    .err_clr   (err_clr),
    .fifo      (fif.master),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .rx_count  (rx_count)
  );

  always #5 clk_w = ~clk_w;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int dbl    = 0;
  logic prev_wr = 1'b0;
  logic [7:0] push_q[$];

  always @(negedge clk_w) begin
    if (fif.wr_en === 1'b1) begin
      pushes++;
      push_q.push_back(fif.wr_data);
      if (prev_wr) dbl++;
    end
    prev_wr = fif.wr_en;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_w);
  endtask

  // Leaves rx at the stop-bit value; caller returns the line high.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0; cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i]; cyc(BIT);
    end
    rx = stop; cyc(BIT);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; cyc(1);
    err_clr = 1'b0; cyc(1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       full;
    logic       push;
    logic       ovr;
    logic       fe;
    logic       clr;
  } vec_t;

  vec_t tv[5];

  initial begin
    int p0;
    int exp_cnt;
    logic [7:0] exp_last;
    logic saw_busy;

    tv[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[3] = '{8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[4] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; rx = 1'b1; err_clr = 1'b0; fif.fifo_full = 1'b0;
    cyc(3);
    chk("rst_wr_en",     32'(fif.wr_en),   0);
    chk("rst_wr_data",   32'(fif.wr_data), 0);
    chk("rst_busy",      32'(busy),        0);
    chk("rst_frame_err", 32'(frame_err),   0);
    chk("rst_overrun",   32'(overrun),     0);
    chk("rst_rx_count",  32'(rx_count),    0);
    rst = 1'b0;
    cyc(4);

    exp_cnt  = 0;
    exp_last = 8'h00;
    for (int i = 0; i < 5; i++) begin
      p0 = pushes;
      fif.fifo_full = tv[i].full;
      send_frame(tv[i].d, tv[i].stop);
      rx = 1'b1;
      fif.fifo_full = 1'b0;
      cyc(16);
      if (tv[i].push) exp_last = tv[i].d;
      exp_cnt += int'(tv[i].push);
      chk($sformatf("v%0d_pushes", i),    32'(pushes - p0),  32'(tv[i].push));
      chk($sformatf("v%0d_wr_data", i),   32'(fif.wr_data),  32'(exp_last));
      chk($sformatf("v%0d_overrun", i),   32'(overrun),      32'(tv[i].ovr));
      chk($sformatf("v%0d_frame_err", i), 32'(frame_err),    32'(tv[i].fe));
      chk($sformatf("v%0d_rx_count", i),  32'(rx_count),     32'(exp_cnt));
      chk($sformatf("v%0d_busy", i),      32'(busy),         0);
      if (tv[i].clr) begin
        pulse_clr();
        chk($sformatf("v%0d_clr_ovr", i), 32'(overrun),   0);
        chk($sformatf("v%0d_clr_fe", i),  32'(frame_err), 0);
      end
    end

    // Framing error followed by a long break: busy holds until the line recovers.
    p0 = pushes;
    send_frame(8'h55, 1'b0);
    cyc(10 * BIT);
    chk("brk_frame_err", 32'(frame_err), 1);
    chk("brk_busy_mid",  32'(busy),      1);
    cyc(10 * BIT);
    chk("brk_busy_end",  32'(busy),      1);
    rx = 1'b1;
    cyc(8);
    chk("brk_busy_rel",  32'(busy),         0);
    chk("brk_pushes",    32'(pushes - p0),  0);
    chk("brk_fe_sticky", 32'(frame_err),    1);
    pulse_clr();
    chk("brk_fe_clr",    32'(frame_err),    0);

    // Short glitch: enters START, rejected at the mid-start sample.
    p0 = pushes;
    saw_busy = 1'b0;
    rx = 1'b0; cyc(4); rx = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      if (busy) saw_busy = 1'b1;
    end
    chk("gl_saw_busy", 32'(saw_busy),     1);
    chk("gl_busy",     32'(busy),         0);
    chk("gl_pushes",   32'(pushes - p0),  0);
    chk("gl_fe",       32'(frame_err),    0);
    chk("gl_ovr",      32'(overrun),      0);

    // Back-to-back frames with no idle gap, counted from a fresh reset.
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(4);
    push_q.delete();
    p0 = pushes;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    cyc(16);
    chk("b2b_pushes",   32'(pushes - p0), 3);
    chk("b2b_d0",       32'(push_q.size() > 0 ? push_q[0] : 8'hXX), 32'h00);
    chk("b2b_d1",       32'(push_q.size() > 1 ? push_q[1] : 8'hXX), 32'hFF);
    chk("b2b_d2",       32'(push_q.size() > 2 ? push_q[2] : 8'hXX), 32'h81);
    chk("b2b_rx_count", 32'(rx_count), 3);

    // Reset in the middle of DATA abandons the frame.
    p0 = pushes;
    rx = 1'b0; cyc(3 * BIT);
    chk("mid_busy_pre", 32'(busy), 1);
    rst = 1'b1; cyc(1);
    chk("mid_rst_wr_en",   32'(fif.wr_en),   0);
    chk("mid_rst_wr_data", 32'(fif.wr_data), 0);
    chk("mid_rst_busy",    32'(busy),        0);
    chk("mid_rst_cnt",     32'(rx_count),    0);
    chk("mid_rst_flags",   32'({frame_err, overrun}), 0);
    rx = 1'b1; cyc(2);
    rst = 1'b0;
    cyc(2 * BIT);
    chk("mid_no_push", 32'(pushes - p0), 0);
    push_q.delete();
    send_frame(8'h7E, 1'b1);
    rx = 1'b1;
    cyc(16);
    chk("mid_pushes",   32'(pushes - p0), 1);
    chk("mid_data",     32'(push_q.size() > 0 ? push_q[0] : 8'hXX), 32'h7E);
    chk("mid_wr_data",  32'(fif.wr_data), 32'h7E);
    chk("mid_rx_count", 32'(rx_count), 1);

    chk("no_double_wr_en", 32'(dbl), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
